// File: rtl/ram_arb_pkg.sv
// Shared parameters and helpers for the round-robin RAM host arbiter.
package ram_arb_pkg;

    localparam int DefaultMaxOutstanding = 2;

    // A single host still needs a one-bit ID so routing logic stays uniform.
    function automatic int host_id_width(input int num_hosts);
        return (num_hosts > 2) ? $clog2(num_hosts) : 1;
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of host IDs.
// Each granted request pushes one ID, and each device response pops one.
module arb_id_fifo
    import ram_arb_pkg::*;
#(
    parameter int IdWidth = 1,
    parameter int Depth   = DefaultMaxOutstanding
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [IdWidth-1:0] id_i,
    output logic [IdWidth-1:0] id_o,
    output logic               full_o,
    output logic               empty_o
);

    // A depth-1 FIFO still needs one pointer bit; the pointer simply never advances past 0.
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth) + 1;

    logic [IdWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q, count_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign id_o    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CntW'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; an empty count masks whatever it holds.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= id_i;
        end
    end

endmodule

// File: rtl/ram_host_arbiter.sv
// Round-robin sharing of one req/gnt/rvalid memory device between NumHosts hosts.
// Responses are routed back in order through an ID FIFO.
module ram_host_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NumHosts       = 2,
    parameter int DataWidth      = 32,
    parameter int AddrWidth      = 32,
    parameter int MaxOutstanding = DefaultMaxOutstanding
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumHosts-1:0]             host_req_i,
    output logic [NumHosts-1:0]             host_gnt_o,
    input  logic [NumHosts*AddrWidth-1:0]   host_addr_i,
    input  logic [NumHosts-1:0]             host_we_i,
    input  logic [NumHosts*DataWidth/8-1:0] host_be_i,
    input  logic [NumHosts*DataWidth-1:0]   host_wdata_i,
    output logic [NumHosts-1:0]             host_rvalid_o,
    output logic [DataWidth-1:0]            host_rdata_o,
    output logic [NumHosts-1:0]             host_err_o,
    output logic                            dev_req_o,
    input  logic                            dev_gnt_i,
    output logic [AddrWidth-1:0]            dev_addr_o,
    output logic                            dev_we_o,
    output logic [DataWidth/8-1:0]          dev_be_o,
    output logic [DataWidth-1:0]            dev_wdata_o,
    input  logic                            dev_rvalid_i,
    input  logic [DataWidth-1:0]            dev_rdata_i,
    input  logic                            dev_err_i,
    output logic                            unexp_rsp_o
);

    localparam int IdW = host_id_width(NumHosts);
    localparam int BeW = DataWidth / 8;

    logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0] winner, cand, head_id;
    logic           found, grant, pop, fifo_full, fifo_empty;

    // First requester at or after rr_ptr, wrapping around the host list.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int i = 0; i < NumHosts; i++) begin
            cand = IdW'((int'(rr_ptr_q) + i) % NumHosts);
            if (!found && host_req_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // No full-bypass: a pop in the same cycle does not free a slot until the next cycle.
    assign dev_req_o   = (|host_req_i) && !fifo_full;
    assign grant       = dev_req_o && dev_gnt_i;
    assign dev_addr_o  = dev_req_o ? host_addr_i[winner*AddrWidth +: AddrWidth] : '0;
    assign dev_we_o    = dev_req_o ? host_we_i[winner] : 1'b0;
    assign dev_be_o    = dev_req_o ? host_be_i[winner*BeW +: BeW] : '0;
    assign dev_wdata_o = dev_req_o ? host_wdata_i[winner*DataWidth +: DataWidth] : '0;

    assign pop          = dev_rvalid_i && !fifo_empty;
    assign unexp_rsp_o  = dev_rvalid_i && fifo_empty;
    assign host_rdata_o = dev_rdata_i;

    for (genvar gi = 0; gi < NumHosts; gi++) begin : g_host
        assign host_gnt_o[gi]    = grant && (winner == IdW'(gi));
        assign host_rvalid_o[gi] = pop && (head_id == IdW'(gi));
        assign host_err_o[gi]    = pop && (head_id == IdW'(gi)) && dev_err_i;
    end

    // The last winner drops to lowest priority.
    assign rr_ptr_d = !grant ? rr_ptr_q :
                      (winner == IdW'(NumHosts - 1)) ? '0 : winner + IdW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    arb_id_fifo #(
        .IdWidth (IdW),
        .Depth   (MaxOutstanding)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant),
        .pop_i   (pop),
        .id_i    (winner),
        .id_o    (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule
